// File: rtl/spi_osc_regfile.sv
// ============================================================================
//  Module   : spi_osc_regfile
//  Purpose  : SPI-slave command front end that decodes byte-framed commands
//             into per-channel wave/freq/phase/amp registers for NUM_OSC
//             oscillators. Optional macro SPI_TIMEOUT_EN aborts stalled payloads.
//  Revision : 1.0  initial multi-oscillator release
// ============================================================================
`default_nettype none

module spi_osc_regfile #(
    parameter int NUM_OSC     = 2,
    parameter int FREQ_W      = 24,
    parameter int PHASE_W     = 16,
    parameter int AMP_W       = 16,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic                        i_clk50mhz,
    input  logic                        i_rst_n,
    input  logic                        i_spi_clk,
    input  logic                        i_spi_mosi,
    input  logic                        i_spi_ss,
    output logic                        o_spi_miso,
    output logic [NUM_OSC*8-1:0]        o_wave,
    output logic [NUM_OSC*FREQ_W-1:0]   o_freq,
    output logic [NUM_OSC*PHASE_W-1:0]  o_phase,
    output logic [NUM_OSC*AMP_W-1:0]    o_amp,
    output logic [NUM_OSC-1:0]          o_update,
    output logic                        o_busy
);

    localparam int c_FREQ_BYTES  = (FREQ_W + 7) / 8;
    localparam int c_PHASE_BYTES = (PHASE_W + 7) / 8;
    localparam int c_AMP_BYTES   = (AMP_W + 7) / 8;
    localparam int c_FP_BYTES    = (c_FREQ_BYTES > c_PHASE_BYTES) ? c_FREQ_BYTES : c_PHASE_BYTES;
    localparam int c_STAGE_BYTES = (c_FP_BYTES > c_AMP_BYTES) ? c_FP_BYTES : c_AMP_BYTES;
    localparam int c_STAGE_W     = 8 * c_STAGE_BYTES;

    localparam logic [4:0] c_NUM_OSC   = 5'(NUM_OSC);
    localparam logic [3:0] c_CODE_WAVE = 4'd1;
    localparam logic [3:0] c_CODE_FREQ = 4'd2;
    localparam logic [3:0] c_CODE_PHASE = 4'd3;
    localparam logic [3:0] c_CODE_AMP  = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    // Bit [2] of the SCLK/SS pipes is the previous synchronised value for edge detection
    logic [2:0] r_sclk_sync;
    logic [2:0] r_ss_sync;
    logic [1:0] r_mosi_sync;

    always_ff @(posedge i_clk50mhz) begin
        if (!i_rst_n) begin
            r_sclk_sync <= 3'b000;
            r_ss_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i_spi_clk};
            r_ss_sync   <= {r_ss_sync[1:0], i_spi_ss};
            r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
        end
    end

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_low;
    logic w_ss_edge;
    logic w_mosi;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_ss_low    = ~r_ss_sync[1];
    assign w_ss_edge   = r_ss_sync[1] ^ r_ss_sync[2];
    assign w_mosi      = r_mosi_sync[1];

    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_rx_byte;
    logic       r_rx_valid;

    always_ff @(posedge i_clk50mhz) begin
        if (!i_rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_ss_edge) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sclk_rise && w_ss_low) begin
                r_shift <= {r_shift[6:0], w_mosi};
                if (r_bit_cnt == 3'd7) begin
                    r_bit_cnt  <= 3'd0;
                    r_rx_byte  <= {r_shift[6:0], w_mosi};
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

    // The first SCLK fall after a load ends the current byte, so it must not shift the echo
    logic [7:0] r_miso_shift;
    logic       r_miso_hold;
    logic       r_miso;

    always_ff @(posedge i_clk50mhz) begin
        if (!i_rst_n) begin
            r_miso_shift <= 8'd0;
            r_miso_hold  <= 1'b0;
            r_miso       <= 1'b0;
        end else begin
            if (r_rx_valid) begin
                r_miso_shift <= r_rx_byte;
                r_miso_hold  <= 1'b1;
            end else if (w_sclk_fall && w_ss_low) begin
                if (r_miso_hold) begin
                    r_miso_hold <= 1'b0;
                end else begin
                    r_miso_shift <= {r_miso_shift[6:0], 1'b0};
                end
            end
            r_miso <= w_ss_low ? r_miso_shift[7] : 1'b0;
        end
    end

    assign o_spi_miso = r_miso;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_index;
    logic [3:0]             r_code;
    logic [7:0]             r_byte_cnt;
    logic [7:0]             r_byte_idx;
    logic [c_STAGE_W-1:0]   r_stage;
    logic [c_STAGE_W-1:0]   w_stage_merged;
    logic [7:0]             w_cmd_bytes;
    logic                   w_cmd_valid;
    logic                   w_latch_cmd;
    logic                   w_take_byte;
    logic                   w_commit;
    logic                   w_abort;
    logic                   w_timeout;

    assign w_cmd_valid = (r_rx_byte[3:0] >= c_CODE_WAVE) && (r_rx_byte[3:0] <= c_CODE_AMP)
                       && ({1'b0, r_rx_byte[7:4]} < c_NUM_OSC);

    always_comb begin
        w_cmd_bytes = 8'd0;
        case (r_rx_byte[3:0])
            c_CODE_WAVE:  w_cmd_bytes = 8'd1;
            c_CODE_FREQ:  w_cmd_bytes = 8'(c_FREQ_BYTES);
            c_CODE_PHASE: w_cmd_bytes = 8'(c_PHASE_BYTES);
            c_CODE_AMP:   w_cmd_bytes = 8'(c_AMP_BYTES);
            default:      w_cmd_bytes = 8'd0;
        endcase
    end

    always_comb begin
        w_stage_merged = r_stage;
        for (int b = 0; b < c_STAGE_BYTES; b++) begin
            if (r_byte_idx == 8'(b)) begin
                w_stage_merged[8*b +: 8] = r_rx_byte;
            end
        end
    end

    always_ff @(posedge i_clk50mhz) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch_cmd  = 1'b0;
        w_take_byte  = 1'b0;
        w_commit     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rx_valid && w_cmd_valid) begin
                    w_latch_cmd  = 1'b1;
                    w_state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (r_rx_valid) begin
                    w_take_byte = 1'b1;
                    if (r_byte_cnt == 8'd1) begin
                        w_commit     = 1'b1;
                        w_state_next = S_COMMIT;
                    end
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk50mhz) begin
        if (!i_rst_n) begin
            r_index    <= 4'd0;
            r_code     <= 4'd0;
            r_byte_cnt <= 8'd0;
            r_byte_idx <= 8'd0;
            r_stage    <= '0;
        end else if (w_latch_cmd) begin
            r_index    <= r_rx_byte[7:4];
            r_code     <= r_rx_byte[3:0];
            r_byte_cnt <= w_cmd_bytes;
            r_byte_idx <= 8'd0;
            r_stage    <= '0;
        end else if (w_take_byte) begin
            r_stage    <= w_stage_merged;
            r_byte_cnt <= r_byte_cnt - 8'd1;
            r_byte_idx <= r_byte_idx + 8'd1;
        end else if (w_abort) begin
            r_stage <= '0;
        end
    end

`ifdef SPI_TIMEOUT_EN
    localparam int                c_TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYC);

    logic [c_TO_W-1:0] r_timeout_cnt;

    always_ff @(posedge i_clk50mhz) begin
        if (!i_rst_n || (r_state != S_PAYLOAD) || r_rx_valid) begin
            r_timeout_cnt <= '0;
        end else if (!w_timeout) begin
            r_timeout_cnt <= r_timeout_cnt + c_TO_W'(1);
        end
    end

    assign w_timeout = (r_timeout_cnt == c_TO_LIMIT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
    assign w_timeout        = 1'b0;
`endif

    // Fields load on the last payload byte so value and o_update appear in the COMMIT cycle
    for (genvar k = 0; k < NUM_OSC; k++) begin : g_ch
        logic               w_sel;
        logic [7:0]         r_wave_ch;
        logic [FREQ_W-1:0]  r_freq_ch;
        logic [PHASE_W-1:0] r_phase_ch;
        logic [AMP_W-1:0]   r_amp_ch;
        logic               r_upd_ch;

        assign w_sel = w_commit && (r_index == 4'(k));

        always_ff @(posedge i_clk50mhz) begin
            if (!i_rst_n) begin
                r_wave_ch  <= 8'd0;
                r_freq_ch  <= '0;
                r_phase_ch <= '0;
                r_amp_ch   <= '0;
                r_upd_ch   <= 1'b0;
            end else begin
                r_upd_ch <= w_sel;
                if (w_sel) begin
                    case (r_code)
                        c_CODE_WAVE:  r_wave_ch  <= w_stage_merged[7:0];
                        c_CODE_FREQ:  r_freq_ch  <= w_stage_merged[FREQ_W-1:0];
                        c_CODE_PHASE: r_phase_ch <= w_stage_merged[PHASE_W-1:0];
                        c_CODE_AMP:   r_amp_ch   <= w_stage_merged[AMP_W-1:0];
                        default:      ;
                    endcase
                end
            end
        end

        assign o_wave[8*k +: 8]             = r_wave_ch;
        assign o_freq[FREQ_W*k +: FREQ_W]   = r_freq_ch;
        assign o_phase[PHASE_W*k +: PHASE_W] = r_phase_ch;
        assign o_amp[AMP_W*k +: AMP_W]      = r_amp_ch;
        assign o_update[k]                  = r_upd_ch;
    end

    assign o_busy = (r_state != S_IDLE);

endmodule

`default_nettype wire
